uart_rx_8n1: RTL and testbench

Asynchronous serial receiver, 8 data bits, no parity, 1 stop bit (8N1), LSB first. It is the receive-side counterpart of `uart_tx` on the Nexys3 UART tests. It deserialises the board `rx` pin, or a loopback of `uart_tx.tx`, into bytes. Each byte is presented to downstream control logic as a one-cycle `valid` pulse with a frame-error flag.

---
 rtl/uart_rx_8n1.sv | 143 ++++++++++++++
 tb/tb_uart_rx_8n1.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle valid/frame_err pulses.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling (decisions one cycle later).
module uart_rx_8n1 #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF         = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
`ifdef UART_RX_MAJORITY_EN
    localparam int START_PT     = HALF;
`else
    localparam int START_PT     = HALF - 1;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] START_CNT = CNT_W'(START_PT);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             ferr_q, ferr_d;
    logic             busy_q, busy_d;
    logic             rxs;
    logic             sample;

    assign rxs = sync_q[1];

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] is rxs one cycle back (nominal point), hist_q[1] two cycles back.
    logic [1:0] hist_q, hist_d;

    always_comb begin
        hist_d = {hist_q[0], rxs};
        sample = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (rst) hist_q <= 2'b11;
        else     hist_q <= hist_d;
    end
`else
    always_comb sample = rxs;
`endif

    always_comb begin
        sync_d  = {sync_q[0], rx};
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                if (cnt_q == START_CNT) begin
                    cnt_d = '0;
                    idx_d = 3'd0;
                    state_d = sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {sample, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets the next start edge follow with no idle gap.
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    data_d = shift_q;
                    if (sample) begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= 3'd0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
        shift_q <= shift_d;
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Scoreboard bench for uart_rx_8n1 at 16 clocks per bit; honours UART_RX_MAJORITY_EN.
module tb_uart_rx_8n1;

    localparam int C    = 16;
    localparam int HALF = C / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int M = 1;
`else
    localparam int M = 0;
`endif
    // Start bit driven at a negedge with cycle count n; first sampling edge is n+1.
    localparam int LAT = 1 + 2 + HALF + 9 * C + M;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int nvalid = 0;
    int nerr   = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    uart_rx_8n1 #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic glitch);
        exp_t e;
        e.is_err = ~stop_v;
        e.d      = b;
        e.cyc    = cyc + LAT;
        sb.push_back(e);
        rx = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            if (glitch && i == 3) begin
                repeat (HALF) @(negedge clk);
                rx = ~b[i];
                @(negedge clk);
                rx = b[i];
                repeat (C - HALF - 1) @(negedge clk);
            end else begin
                repeat (C) @(negedge clk);
            end
        end
        rx = stop_v;
        repeat (C) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every output pulse.
    initial begin
        exp_t e;
        logic busy_prev = 1'b0;
        logic pulse_prev = 1'b0;
        int   rise_cyc = 0;
        forever begin
            @(negedge clk);
            if (busy && !busy_prev) rise_cyc = cyc;
            busy_prev = busy;
            if (valid || frame_err) begin
                if (valid) nvalid++;
                if (frame_err) nerr++;
                check("pulse_exclusive", {31'd0, valid & frame_err}, 32'd0);
                check("pulse_not_consecutive", {31'd0, pulse_prev}, 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: got valid=%0b frame_err=%0b data=%0h expected none", valid, frame_err, data);
                end else begin
                    e = sb.pop_front();
                    check("pulse_kind_frame_err", {31'd0, frame_err}, {31'd0, e.is_err});
                    check("data", {24'd0, data}, {24'd0, e.d});
                    check("latency_cycle", cyc, e.cyc);
                    if (valid) begin
                        check("busy_low_at_valid", {31'd0, busy}, 32'd0);
                        check("busy_span", cyc - rise_cyc, HALF + 9 * C + M);
                    end
                end
            end
            pulse_prev = valid | frame_err;
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        string s;
        s = "Hello from UART!";
        repeat (4) @(negedge clk);
        check("reset_data", {24'd0, data}, 32'h00);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (C) @(negedge clk);

        // Single good frame.
        send_frame(8'h55, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);

        // Short low glitch on idle line is a false start.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (HALF + 2) @(negedge clk);
        check("glitch_busy_cleared", {31'd0, busy}, 32'd0);
        check("glitch_data_held", {24'd0, data}, 32'h55);
        repeat (C) @(negedge clk);

        // Bad stop bit followed by a long break, then recovery.
        send_frame(8'hA3, 1'b0, 1'b0);
        repeat (50 * C) @(negedge clk);
        check("break_busy_held", {31'd0, busy}, 32'd1);
        repeat (50 * C) @(negedge clk);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);
        check("break_released", {31'd0, busy}, 32'd0);
        send_frame(8'h0D, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);

        // Reset in the middle of data bit 4 of 0xFF.
        rx = 1'b0;
        repeat (C) @(negedge clk);
        rx = 1'b1;
        repeat (4 * C + HALF) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {24'd0, data}, 32'h00);
        rst = 1'b0;
        repeat (6 * C) @(negedge clk);
        send_frame(8'h0A, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (2 * C) @(negedge clk);

        // Back-to-back message, no idle between frames.
        for (int i = 0; i < s.len(); i++) begin
`ifdef UART_RX_MAJORITY_EN
            send_frame(s[i], 1'b1, i == 0);
`else
            send_frame(s[i], 1'b1, 1'b0);
`endif
        end
        send_frame(8'h0D, 1'b1, 1'b0);
        send_frame(8'h0A, 1'b1, 1'b0);
        rx = 1'b1;
        repeat (3 * C) @(negedge clk);

        check("scoreboard_drained", sb.size(), 32'd0);
        check("total_valid", nvalid, 32'd21);
        check("total_frame_err", nerr, 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
